// File: rtl/controle_bloqueio.sv
// DigiLock access/lockout controller.
// Drives contador_9b and uses its value as the open/lockout time base.
module controle_bloqueio #(
  parameter int unsigned MAX_FAILS  = 3,
  parameter logic [8:0]  OPEN_TICKS = 9'd100,
  parameter logic [8:0]  LOCK_TICKS = 9'd300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       attempt_valid,
  input  logic       attempt_ok,
  input  logic       close,
  input  logic [8:0] count_s,
  output logic       cnt_add,
  output logic       cnt_reset,
  output logic       unlocked,
  output logic       locked_out,
  output logic [3:0] fail_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam logic [4:0] MF        = 5'(MAX_FAILS);
  localparam logic [8:0] OPEN_LAST = OPEN_TICKS - 9'd1;
  localparam logic [8:0] LOCK_LAST = LOCK_TICKS - 9'd1;

  state_t     state_q, state_d;
  logic [3:0] fail_q, fail_d;
  logic [4:0] fail_inc;
  logic       unlocked_q, locked_q;
  logic       add_q, clr_q;

  // Widened so the compare against MAX_FAILS cannot overflow.
  assign fail_inc = {1'b0, fail_q} + 5'd1;

  // Next-state and failure-count decode.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    unique case (state_q)
      IDLE: begin
        if (attempt_valid) begin
          if (attempt_ok) begin
            state_d = OPEN;
            fail_d  = 4'd0;
          end else if (fail_inc >= MF) begin
            state_d = LOCKOUT;
            fail_d  = 4'd0;
          end else begin
            fail_d  = fail_inc[3:0];
          end
        end
      end
      OPEN: begin
        if (close)
          state_d = IDLE;
        else if (count_s >= OPEN_LAST)
          state_d = IDLE;
      end
      LOCKOUT: begin
        if (count_s >= LOCK_LAST)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      fail_q     <= 4'd0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
      add_q      <= 1'b0;
      clr_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      unlocked_q <= (state_d == OPEN);
      locked_q   <= (state_d == LOCKOUT);
      add_q      <= (state_d != IDLE);
      clr_q      <= (state_d == IDLE);
    end
  end

  assign unlocked   = unlocked_q;
  assign locked_out = locked_q;
  assign cnt_add    = add_q;
  assign cnt_reset  = clr_q;
  assign fail_count = fail_q;

endmodule
